// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode queue bus: fetch-side and decode-side valid/ready handshakes plus flush and occupancy.
// The master modport is the fetch/decode environment; the slave modport is the queue itself.
interface fetch_decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [XLEN-1:0]          in_instr;
  logic [XLEN-1:0]          in_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_instr;
  logic [XLEN-1:0]          out_pc;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular {instr, pc} buffer between fetch and decode; flush (take_branch) drops all wrong-path entries.
// Optional same-cycle bypass on an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_decode_queue #(
  parameter int              DEPTH     = 4,
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_decode_queue_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   cnt;

  logic empty;
  logic full;
  logic push;
  logic byp;
  logic wr_en;
  logic rd_en;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  // in_ready comes only from registered state, so a full queue never takes a beat even while popping
  assign bus.in_ready = rst & ~full;
  assign push         = bus.in_valid & bus.in_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = rst & empty & bus.in_valid & ~bus.flush;
`else
  assign byp = 1'b0;
`endif

  // a bypassed beat that decode takes immediately never touches the array
  assign wr_en = push & ~(byp & bus.out_ready);
  assign rd_en = ~empty & bus.out_ready;

  assign bus.out_valid = ~empty | byp;
  assign bus.count     = cnt;

  always_comb begin
    bus.out_instr = NOP_INSTR;
    bus.out_pc    = '0;
    if (!empty) begin
      bus.out_instr = mem_instr[rptr];
      bus.out_pc    = mem_pc[rptr];
    end else if (byp) begin
      bus.out_instr = bus.in_instr;
      bus.out_pc    = bus.in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !bus.flush) begin
      mem_instr[wptr] <= bus.in_instr;
      mem_pc[wptr]    <= bus.in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: reset, fill/drain, streaming across wrap, flush, full+pop, bypass, async reset.
module tb_fetch_decode_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] exp_pc [5];
  logic        pend;

  fetch_decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_decode_queue #(
    .DEPTH(DEPTH),
    .XLEN(XLEN),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = 32'hA000_0000 | pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
    #1;
  endtask

  initial begin
    exp_pc[0] = 32'h00; exp_pc[1] = 32'h04; exp_pc[2] = 32'h08;
    exp_pc[3] = 32'h0C; exp_pc[4] = 32'h10;

    // reset held with fetch offering a beat
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr,      32'h13);
    chk("rst_out_pc",    bus.out_pc,         32'h0);
    chk("rst_count",     32'(bus.count),     32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("rel_in_ready",  32'(bus.in_ready),  32'd1);

    // fill to DEPTH with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      chk("fill_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    chk("full_count",    32'(bus.count),     32'd4);
    chk("full_in_ready", 32'(bus.in_ready),  32'd0);
    chk("full_head_pc",  bus.out_pc,         32'h0);
    tick();
    chk("full_hold",     32'(bus.count),     32'd4);

    // drain; fetch keeps offering 0x10 until accepted
    pend = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(pend, 32'h10, 1'b1, 1'b0);
      chk("drain_pc",    bus.out_pc,    exp_pc[i]);
      chk("drain_instr", bus.out_instr, 32'hA000_0000 | exp_pc[i]);
      if (i < 2) chk("drain_ready", 32'(bus.in_ready), 32'(i));
      if (pend && bus.in_ready) pend = 1'b0;
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("drain_count",     32'(bus.count),     32'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_nop",       bus.out_instr,      32'h13);

    // streaming across the pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
      chk("stream_pc",    bus.out_pc,         32'(i * 4));
      chk("stream_count", 32'(bus.count),     32'd0);
`else
      if (i == 0) begin
        chk("stream_valid0", 32'(bus.out_valid), 32'd0);
      end else begin
        chk("stream_pc",    bus.out_pc,     32'((i - 1) * 4));
        chk("stream_count", 32'(bus.count), 32'd1);
      end
`endif
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
`ifndef FETCH_QUEUE_BYPASS_EN
    chk("stream_last", bus.out_pc, 32'h24);
`endif
    tick();
    chk("stream_empty", 32'(bus.count), 32'd0);

    // flush discards wrong-path entries and the beat offered with it
    drive(1'b1, 32'h10, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h14, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h18, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(bus.count), 32'd3);
    drive(1'b1, 32'h1C, 1'b1, 1'b1);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("flush_count", 32'(bus.count),     32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_pc",    bus.out_pc,         32'h0);
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("redirect_pc",    bus.out_pc,     32'h80);
    chk("redirect_instr", bus.out_instr,  32'hA000_0080);
    chk("redirect_count", 32'(bus.count), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("redirect_empty", 32'(bus.count), 32'd0);

    // full with a simultaneous pop: no pop-through
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(32'h20 + i * 4), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h30, 1'b1, 1'b0);
    chk("fullpop_ready", 32'(bus.in_ready), 32'd0);
    chk("fullpop_pc",    bus.out_pc,        32'h20);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fullpop_count",  32'(bus.count),    32'd3);
    chk("fullpop_ready2", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fullpop_drain", bus.out_pc, 32'(32'h24 + i * 4));
      tick();
    end
    chk("fullpop_empty", 32'(bus.count), 32'd0);

    // empty-queue latency (bypass vs. registered)
    drive(1'b1, 32'h40, 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_valid", 32'(bus.out_valid), 32'd1);
    chk("byp_pc",    bus.out_pc,         32'h40);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("byp_count", 32'(bus.count), 32'd0);
`else
    chk("nobyp_valid", 32'(bus.out_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("nobyp_pc",    bus.out_pc,     32'h40);
    chk("nobyp_count", 32'(bus.count), 32'd1);
    tick();
    chk("nobyp_empty", 32'(bus.count), 32'd0);
`endif

    // reset mid-operation drops everything immediately
    drive(1'b1, 32'h50, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid_count", 32'(bus.count), 32'd2);
    rst = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus.count),     32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready),  32'd0);
    chk("mid_rst_instr", bus.out_instr,      32'h13);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rel_ready", 32'(bus.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
